// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall vector layout,
// timer FSM encoding, canned stall patterns and reset level.
package pipe_ctrl_pkg;

   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // Multi-cycle EX op holds pc..ex; a load-use hazard holds pc..id only.
   localparam logic [STALL_W-1:0] STALL_VEC_EX = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_VEC_LU = 6'b000111;

   localparam logic RST_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mc_state_e;

endpackage

// File: rtl/multi_cycle_timer.sv
// Occupancy timer for MULT/DIV in EX: IDLE -> BUSY (N-2 cycles) -> DONE, abortable by flush.
module multi_cycle_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 33,
   parameter int CNT_W       = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic div_i,
   input  logic flush_i,
   output logic busy_o,
   output logic done_o,
   output logic ex_stall_o
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

   mc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] load_val;

   assign load_val = div_i ? DIV_LOAD : MULT_LOAD;

   // The counter holds the BUSY cycles still to run; DONE follows the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               cnt_d   = load_val;
               state_d = (load_val == '0) ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (flush_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE) && !flush_i;
   assign ex_stall_o = ((state_q == ST_IDLE) && start_i) || (state_q == ST_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller: load-use detection, multi-cycle EX hold, flush priority.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 33,
   parameter int CNT_W       = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_en_read1_i,
   input  logic [4:0]         id_reg_addr1_i,
   input  logic               id_en_read2_i,
   input  logic [4:0]         id_reg_addr2_i,
   input  logic               ex_is_load_i,
   input  logic [4:0]         ex_wd_i,
   input  logic               ex_multi_start_i,
   input  logic               ex_multi_div_i,
   input  logic               flush_i,
`ifdef PIPE_CTRL_PERF_EN
   input  logic               perf_clr_i,
   output logic [31:0]        perf_stall_cycles_o,
   output logic [31:0]        perf_loaduse_o,
   output logic [31:0]        perf_multi_o,
`endif
   output logic [STALL_W-1:0] stall_o,
   output logic               bubble_ex_o,
   output logic               flush_o,
   output logic               multi_done_o,
   output logic               busy_o
);

   logic timer_busy;
   logic timer_done;
   logic ex_stall;
   logic load_use;
   logic in_reset;

   multi_cycle_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start_i    (ex_multi_start_i),
      .div_i      (ex_multi_div_i),
      .flush_i    (flush_i),
      .busy_o     (timer_busy),
      .done_o     (timer_done),
      .ex_stall_o (ex_stall)
   );

   assign in_reset = (rst == RST_ACTIVE);

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = ex_is_load_i && (ex_wd_i != 5'd0) &&
                     ((id_en_read1_i && (id_reg_addr1_i == ex_wd_i)) ||
                      (id_en_read2_i && (id_reg_addr2_i == ex_wd_i)));

   always_comb begin
      stall_o     = '0;
      bubble_ex_o = 1'b0;
      flush_o     = 1'b0;
      if (!in_reset) begin
         if (flush_i) begin
            flush_o = 1'b1;
         end else if (ex_stall) begin
            stall_o = STALL_VEC_EX;
         end else if (load_use) begin
            stall_o     = STALL_VEC_LU;
            bubble_ex_o = 1'b1;
         end
      end
   end

   assign multi_done_o = timer_done && !in_reset;
   assign busy_o       = timer_busy;

`ifdef PIPE_CTRL_PERF_EN
   logic [2:0]       perf_inc;
   logic [2:0][31:0] perf_cnt;

   assign perf_inc = {multi_done_o, bubble_ex_o, |stall_o};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_perf
         logic [31:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (perf_clr_i) begin
               cnt_d = '0;
            end else if (perf_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt_q <= '0;
            else      cnt_q <= cnt_d;
         end

         assign perf_cnt[gi] = cnt_q;
      end
   endgenerate

   assign perf_stall_cycles_o = perf_cnt[0];
   assign perf_loaduse_o      = perf_cnt[1];
   assign perf_multi_o        = perf_cnt[2];
`endif

endmodule
